fixture_pms_top: RTL and testbench

FIXTURE_PMS_TOP -- requirements
Module: fixture_pms_top

---
 rtl/fixture_pms_top.sv | 216 +++++++++++++++++++++
 tb/tb_fixture_pms_top.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixture_pms_top.sv
// Platform management block: boot/control register file plus an ACPI-style
// power-button state machine (debounced button, short press = on/irq, long press = off).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_S5      | soft-off; a short press powers on
// ST_S0      | running; short press raises irq, long press forces off
// ST_S5_WAIT | forced off, waiting for the long press to be released
module fixture_pms_top #(
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned LONG_PRESS_CYCLES = 4000,
    parameter logic [31:0] BOOT_ADDR_RST     = 32'h1C00_8080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reg_req_i,
    input  logic        reg_we_i,
    input  logic [7:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o,
    output logic        reg_ready_o,
    input  logic        pwr_btn_ni,
    input  logic        eoc_i,
    input  logic [31:0] exit_status_i,
    output logic [1:0]  bootmode_o,
    output logic [31:0] boot_addr_o,
    output logic        fetch_en_o,
    output logic        uart_rx_en_o,
    output logic [1:0]  pwr_state_o,
    output logic        slp_s5_no,
    output logic        pwr_btn_irq_o
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned     LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    localparam logic [7:0] ADDR_BOOTMODE  = 8'h00;
    localparam logic [7:0] ADDR_BOOT_ADDR = 8'h04;
    localparam logic [7:0] ADDR_FETCH_EN  = 8'h08;
    localparam logic [7:0] ADDR_UART_CTRL = 8'h0C;
    localparam logic [7:0] ADDR_STATUS    = 8'h10;
    localparam logic [7:0] ADDR_EXIT      = 8'h14;
    localparam logic [7:0] ADDR_IRQ_CLR   = 8'h18;

    localparam logic [1:0] PWR_S0 = 2'b00;
    localparam logic [1:0] PWR_S5 = 2'b11;

    typedef enum logic [1:0] {
        ST_S5      = 2'b00,
        ST_S0      = 2'b01,
        ST_S5_WAIT = 2'b10
    } pwr_st_e;

    pwr_st_e     state_q;
    logic [1:0]  pwr_state_q;
    logic        slp_s5_n_q;
    logic        irq_q;

    logic [1:0]  bootmode_q;
    logic [31:0] boot_addr_q;
    logic        fetch_en_q;
    logic        uart_rx_en_q;
    logic        reg_ready_q;
    logic [31:0] reg_rdata_q;
    logic [31:0] rdata_d;
    logic        wr_en;
    logic        irq_clr;

    logic            sync1_q;
    logic            sync2_q;
    logic            deb_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            db_flip;
    logic            rel_evt;
    logic [LP_W-1:0] press_cnt_q;
    logic            long_hit;
    logic            short_rel;

    // ---------------- register file ----------------
    assign wr_en   = reg_req_i & reg_we_i;
    assign irq_clr = wr_en & (reg_addr_i == ADDR_IRQ_CLR) & reg_wdata_i[0];

    always_comb begin
        rdata_d = '0;
        case (reg_addr_i)
            ADDR_BOOTMODE:  rdata_d = {30'd0, bootmode_q};
            ADDR_BOOT_ADDR: rdata_d = boot_addr_q;
            ADDR_FETCH_EN:  rdata_d = {31'd0, fetch_en_q};
            ADDR_UART_CTRL: rdata_d = {31'd0, uart_rx_en_q};
            ADDR_STATUS:    rdata_d = {27'd0, irq_q, pwr_state_q, 1'b0, eoc_i};
            ADDR_EXIT:      rdata_d = exit_status_i;
            default:        rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bootmode_q   <= 2'b00;
            boot_addr_q  <= BOOT_ADDR_RST;
            fetch_en_q   <= 1'b0;
            uart_rx_en_q <= 1'b0;
            reg_ready_q  <= 1'b0;
            reg_rdata_q  <= '0;
        end else begin
            reg_ready_q <= reg_req_i;
            reg_rdata_q <= (reg_req_i && !reg_we_i) ? rdata_d : '0;
            if (wr_en) begin
                case (reg_addr_i)
                    ADDR_BOOTMODE:  bootmode_q   <= reg_wdata_i[1:0];
                    ADDR_BOOT_ADDR: boot_addr_q  <= reg_wdata_i;
                    ADDR_FETCH_EN:  fetch_en_q   <= reg_wdata_i[0];
                    ADDR_UART_CTRL: uart_rx_en_q <= reg_wdata_i[0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- button synchronizer and debounce ----------------
    // Down-counter reloads whenever the synchronized level agrees with the
    // debounced one, so only an unbroken run of disagreement flips it.
    assign db_flip = (sync2_q != deb_q) && (db_cnt_q == '0);
    assign rel_evt = db_flip & ~deb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            deb_q    <= 1'b1;
            db_cnt_q <= DB_LOAD;
        end else begin
            sync1_q <= pwr_btn_ni;
            sync2_q <= sync1_q;
            if (sync2_q == deb_q) begin
                db_cnt_q <= DB_LOAD;
            end else if (db_flip) begin
                deb_q    <= ~deb_q;
                db_cnt_q <= DB_LOAD;
            end else begin
                db_cnt_q <= db_cnt_q - 1'b1;
            end
        end
    end

    // ---------------- press duration ----------------
    assign long_hit  = ~deb_q & ~rel_evt & (press_cnt_q == LP_LAST);
    assign short_rel = rel_evt & (press_cnt_q < LP_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            press_cnt_q <= '0;
        end else if (deb_q || rel_evt) begin
            press_cnt_q <= '0;
        end else if (press_cnt_q != LP_MAX) begin
            press_cnt_q <= press_cnt_q + 1'b1;
        end
    end

    // ---------------- power state machine ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_S5;
            pwr_state_q <= PWR_S5;
            slp_s5_n_q  <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_S5: begin
                    if (short_rel) begin
                        state_q     <= ST_S0;
                        pwr_state_q <= PWR_S0;
                        slp_s5_n_q  <= 1'b1;
                    end
                end
                ST_S0: begin
                    if (long_hit) begin
                        state_q     <= ST_S5_WAIT;
                        pwr_state_q <= PWR_S5;
                        slp_s5_n_q  <= 1'b0;
                        irq_q       <= 1'b0;
                    end else if (short_rel) begin
                        irq_q <= 1'b1;
                    end else if (irq_clr) begin
                        irq_q <= 1'b0;
                    end
                end
                ST_S5_WAIT: begin
                    if (rel_evt) begin
                        state_q <= ST_S5;
                        irq_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_S5;
                    pwr_state_q <= PWR_S5;
                    slp_s5_n_q  <= 1'b0;
                    irq_q       <= 1'b0;
                end
            endcase
        end
    end

    assign reg_rdata_o   = reg_rdata_q;
    assign reg_ready_o   = reg_ready_q;
    assign bootmode_o    = bootmode_q;
    assign boot_addr_o   = boot_addr_q;
    assign fetch_en_o    = fetch_en_q;
    assign uart_rx_en_o  = uart_rx_en_q;
    assign pwr_state_o   = pwr_state_q;
    assign slp_s5_no     = slp_s5_n_q;
    assign pwr_btn_irq_o = irq_q;

endmodule

// File: tb/tb_fixture_pms_top.sv
// Bench for fixture_pms_top: register table, hand-timed power-button sequences,
// then random button activity checked against a behavioural power model.
module tb_fixture_pms_top;

    localparam int DB = 16;
    localparam int LP = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_req = 1'b0;
    logic        reg_we = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [31:0] reg_wdata = 32'h0;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic        pwr_btn_n = 1'b1;
    logic        eoc = 1'b0;
    logic [31:0] exit_st = 32'h0;
    logic [1:0]  bootmode;
    logic [31:0] boot_addr;
    logic        fetch_en;
    logic        uart_rx_en;
    logic [1:0]  pwr_state;
    logic        slp_s5_n;
    logic        irq;

    int checks = 0;
    int failures = 0;

    fixture_pms_top #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP),
        .BOOT_ADDR_RST    (32'h1C00_8080)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_req_i    (reg_req),
        .reg_we_i     (reg_we),
        .reg_addr_i   (reg_addr),
        .reg_wdata_i  (reg_wdata),
        .reg_rdata_o  (reg_rdata),
        .reg_ready_o  (reg_ready),
        .pwr_btn_ni   (pwr_btn_n),
        .eoc_i        (eoc),
        .exit_status_i(exit_st),
        .bootmode_o   (bootmode),
        .boot_addr_o  (boot_addr),
        .fetch_en_o   (fetch_en),
        .uart_rx_en_o (uart_rx_en),
        .pwr_state_o  (pwr_state),
        .slp_s5_no    (slp_s5_n),
        .pwr_btn_irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural power model ----------------
    // m_pwr: 0 = off, 1 = on, 2 = forced off awaiting release.
    bit m_h0 = 1'b1, m_h1 = 1'b1, m_deb = 1'b1, m_irq = 1'b0;
    int m_run = 0, m_held = 0, m_pwr = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h0 <= 1'b1; m_h1 <= 1'b1; m_deb <= 1'b1; m_irq <= 1'b0;
            m_run <= 0; m_held <= 0; m_pwr <= 0;
        end else begin
            bit sv, deb, rel, set, irq_n;
            int run, held, pwr;
            sv = m_h1; deb = m_deb; run = m_run; pwr = m_pwr; irq_n = m_irq;
            rel = 1'b0; set = 1'b0;
            run = (sv != deb) ? run + 1 : 0;
            if (run == DB) begin
                run = 0; deb = sv; rel = sv;
            end
            if (rel || m_deb) held = 0;
            else held = (m_held < LP) ? m_held + 1 : LP;
            if (rel) begin
                if (pwr == 2) pwr = 0;
                else if (m_held < LP) begin
                    if (pwr == 0) pwr = 1;
                    else set = 1'b1;
                end
            end else if (pwr == 1 && held == LP && m_held < LP) begin
                pwr = 2;
            end
            if (set) irq_n = 1'b1;
            else if (reg_req && reg_we && reg_addr == 8'h18 && reg_wdata[0]) irq_n = 1'b0;
            if (pwr != 1) irq_n = 1'b0;
            m_h1 <= m_h0; m_h0 <= pwr_btn_n;
            m_deb <= deb; m_run <= run; m_held <= held; m_pwr <= pwr; m_irq <= irq_n;
        end
    end

    task automatic model_cmp(input string tag);
        check({tag, "_pwr"}, {30'd0, pwr_state}, (m_pwr == 1) ? 32'd0 : 32'd3);
        check({tag, "_slp"}, {31'd0, slp_s5_n}, (m_pwr == 1) ? 32'd1 : 32'd0);
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
    endtask

    // ---------------- register access (called at a negedge) ----------------
    task automatic reg_acc(input bit we, input logic [7:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
        reg_req = 1'b1; reg_we = we; reg_addr = a; reg_wdata = wd;
        @(negedge clk);
        check("ready_pulse", {31'd0, reg_ready}, 32'd1);
        rd = reg_rdata;
        reg_req = 1'b0; reg_we = 1'b0;
        @(negedge clk);
        check("ready_drop", {31'd0, reg_ready}, 32'd0);
    endtask

    task automatic power_on(input string tag);
        pwr_btn_n = 1'b0;
        repeat (100) @(negedge clk);
        pwr_btn_n = 1'b1;
        repeat (DB + 1) @(negedge clk);
        check({tag, "_pre_on"}, {30'd0, pwr_state}, 32'd3);
        @(negedge clk);
        check({tag, "_on"}, {30'd0, pwr_state}, 32'd0);
        check({tag, "_on_slp"}, {31'd0, slp_s5_n}, 32'd1);
        check({tag, "_on_irq"}, {31'd0, irq}, 32'd0);
    endtask

    task automatic long_off(input string tag);
        pwr_btn_n = 1'b0;
        repeat (DB + 2 + LP - 1) @(negedge clk);
        check({tag, "_pre_off"}, {30'd0, pwr_state}, 32'd0);
        @(negedge clk);
        check({tag, "_off"}, {30'd0, pwr_state}, 32'd3);
        check({tag, "_off_slp"}, {31'd0, slp_s5_n}, 32'd0);
        pwr_btn_n = 1'b1;
        repeat (DB + 40) @(negedge clk);
        check({tag, "_no_reon"}, {30'd0, pwr_state}, 32'd3);
    endtask

    task automatic glitches(input logic [1:0] exp_state, input string tag);
        for (int g = 0; g < 3; g++) begin
            pwr_btn_n = 1'b0;
            repeat (10) @(negedge clk);
            pwr_btn_n = 1'b1;
            repeat (20) @(negedge clk);
        end
        repeat (DB + 4) @(negedge clk);
        check({tag, "_state"}, {30'd0, pwr_state}, {30'd0, exp_state});
        check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    endtask

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        eoc;
        logic [31:0] exit_st;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] rd;

    initial begin
        vecs.push_back('{1'b0, 8'h04, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1C00_8080});
        vecs.push_back('{1'b0, 8'h10, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_000C});
        vecs.push_back('{1'b0, 8'h00, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b0, 8'h08, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b1, 8'h00, 32'h3,         1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, 8'h04, 32'h1C00_8080, 1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, 8'h08, 32'h1,         1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, 8'h0C, 32'h1,         1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, 8'h00, 32'h0,         1'b0, 32'h0,         1'b1, 32'h3});
        vecs.push_back('{1'b0, 8'h08, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1});
        vecs.push_back('{1'b0, 8'h0C, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1});
        vecs.push_back('{1'b1, 8'h04, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, 8'h04, 32'h0,         1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 8'h04, 32'h1C00_8080, 1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, 8'h08, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, 8'h08, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b1, 8'h08, 32'h1,         1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, 8'h00, 32'hFFFF_FFFD, 1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, 8'h00, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1});
        vecs.push_back('{1'b1, 8'h00, 32'h3,         1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, 8'h20, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, 8'h20, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0,         1'b1, 32'h0,         1'b1, 32'h0000_000D});
        vecs.push_back('{1'b0, 8'h14, 32'h0,         1'b0, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001});
        vecs.push_back('{1'b0, 8'h18, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b0, 8'h02, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0});

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, reg_ready}, 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        check("rst_pwr", {30'd0, pwr_state}, 32'd3);
        check("rst_slp", {31'd0, slp_s5_n}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_bootmode", {30'd0, bootmode}, 32'd0);
        check("rst_boot_addr", boot_addr, 32'h1C00_8080);
        check("rst_fetch", {31'd0, fetch_en}, 32'd0);
        check("rst_uart", {31'd0, uart_rx_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            eoc = vecs[i].eoc;
            exit_st = vecs[i].exit_st;
            reg_acc(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end
        eoc = 1'b0;
        exit_st = 32'h0;
        check("out_bootmode", {30'd0, bootmode}, 32'd3);
        check("out_boot_addr", boot_addr, 32'h1C00_8080);
        check("out_fetch", {31'd0, fetch_en}, 32'd1);
        check("out_uart", {31'd0, uart_rx_en}, 32'd1);

        glitches(2'b11, "glitch_s5");
        for (int k = 0; k < 2; k++) begin
            power_on($sformatf("cyc%0d", k));
            long_off($sformatf("cyc%0d", k));
        end
        check("fetch_ungated", {31'd0, fetch_en}, 32'd1);

        power_on("irq");
        glitches(2'b00, "glitch_s0");
        pwr_btn_n = 1'b0;
        repeat (50) @(negedge clk);
        pwr_btn_n = 1'b1;
        repeat (DB + 2) @(negedge clk);
        check("short_irq", {31'd0, irq}, 32'd1);
        check("short_stays_s0", {30'd0, pwr_state}, 32'd0);
        reg_acc(1'b0, 8'h10, 32'h0, rd);
        check("status_irq", rd, 32'h0000_0010);
        reg_acc(1'b1, 8'h18, 32'h1, rd);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        eoc = 1'b1;
        exit_st = 32'h0;
        reg_acc(1'b0, 8'h10, 32'h0, rd);
        check("status_eoc", rd, 32'h0000_0001);
        reg_acc(1'b0, 8'h14, 32'h0, rd);
        check("exit_zero", rd, 32'h0);
        eoc = 1'b0;

        // IRQ_CLR write lands on the same edge as the debounced release.
        pwr_btn_n = 1'b0;
        repeat (50) @(negedge clk);
        pwr_btn_n = 1'b1;
        repeat (DB + 1) @(negedge clk);
        check("pre_set_irq", {31'd0, irq}, 32'd0);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h18; reg_wdata = 32'h1;
        @(negedge clk);
        reg_req = 1'b0; reg_we = 1'b0;
        check("set_wins", {31'd0, irq}, 32'd1);

        pwr_btn_n = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_pwr", {30'd0, pwr_state}, 32'd3);
        check("midrst_slp", {31'd0, slp_s5_n}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_bootmode", {30'd0, bootmode}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (DB + 2 + 60) @(negedge clk);
        check("held_after_rst", {30'd0, pwr_state}, 32'd3);
        pwr_btn_n = 1'b1;
        repeat (DB + 1) @(negedge clk);
        check("fresh_pre_on", {30'd0, pwr_state}, 32'd3);
        @(negedge clk);
        check("fresh_on", {30'd0, pwr_state}, 32'd0);

        model_cmp("sync");
        begin
            bit lvl;
            lvl = 1'b1;
            for (int s = 0; s < 80; s++) begin
                int dur, r;
                lvl = ~lvl;
                pwr_btn_n = lvl;
                r = $urandom_range(0, 9);
                if (r < 3) dur = $urandom_range(1, 15);
                else if (r < 7) dur = $urandom_range(17, 200);
                else dur = $urandom_range(LP, LP + 80);
                for (int c = 0; c < dur; c++) begin
                    @(negedge clk);
                    model_cmp("rand");
                    reg_req = 1'b0; reg_we = 1'b0;
                    if ($urandom_range(0, 39) == 0) begin
                        reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h18; reg_wdata = $urandom;
                    end
                end
            end
            reg_req = 1'b0; reg_we = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
